iris_axil_initiator: RTL and testbench

- AXI-Lite master for the Iris core's load/store path; drives the memory responder on the same bus.
- Converts a simple single-beat request/response interface into AXI-Lite write transactions (AW/W/B channels) or read transactions (AR/R channels).
- Holds exactly one transaction outstanding at a time.
- Data width is 24 bits with one strobe bit per byte.

---
 rtl/iris_axil_if.sv | 37 +++
 rtl/iris_axil_initiator.sv | 168 ++++++++++++++++
 tb/tb_iris_axil_initiator.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iris_axil_if.sv
// AXI-Lite bus bundle between the Iris load/store initiator and its memory responder.
interface iris_axil_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 16
);
  logic                      m_awvalid;
  logic                      m_awready;
  logic [ADDR_WIDTH-1:0]     m_awaddr;
  logic [2:0]                m_awprot;
  logic                      m_wvalid;
  logic                      m_wready;
  logic [DATA_WIDTH-1:0]     m_wdata;
  logic [DATA_WIDTH/8-1:0]   m_wstrb;
  logic                      m_bvalid;
  logic                      m_bready;
  logic [1:0]                m_bresp;
  logic                      m_arvalid;
  logic                      m_arready;
  logic [ADDR_WIDTH-1:0]     m_araddr;
  logic [2:0]                m_arprot;
  logic                      m_rvalid;
  logic                      m_rready;
  logic [DATA_WIDTH-1:0]     m_rdata;
  logic [1:0]                m_rresp;

  modport master (
    output m_awvalid, m_awaddr, m_awprot, m_wvalid, m_wdata, m_wstrb, m_bready,
           m_arvalid, m_araddr, m_arprot, m_rready,
    input  m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rdata, m_rresp
  );

  modport slave (
    input  m_awvalid, m_awaddr, m_awprot, m_wvalid, m_wdata, m_wstrb, m_bready,
           m_arvalid, m_araddr, m_arprot, m_rready,
    output m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rdata, m_rresp
  );
endinterface

// File: rtl/iris_axil_initiator.sv
// Single-outstanding AXI-Lite master turning core load/store requests into AW/W/B or AR/R transfers.
// Optional saturating statistics counters: define IRIS_AXIL_INITIATOR_STATS_EN.
module iris_axil_initiator #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 16,
  parameter int STAT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  iris_axil_if.master             bus,
  output logic [STAT_WIDTH-1:0]   stat_wr_cnt,
  output logic [STAT_WIDTH-1:0]   stat_rd_cnt,
  output logic [STAT_WIDTH-1:0]   stat_err_cnt
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RSP} state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   aw_hs;
  logic   w_hs;

  // SLVERR (10) and DECERR (11) are errors; OKAY and EXOKAY are success.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == 2'b10) || (resp == 2'b11);
  endfunction

  assign aw_hs        = bus.m_awvalid && bus.m_awready;
  assign w_hs         = bus.m_wvalid && bus.m_wready;
  assign bus.m_awprot = 3'b000;
  assign bus.m_arprot = 3'b000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      bus.m_awvalid <= 1'b0;
      bus.m_awaddr  <= '0;
      bus.m_wvalid  <= 1'b0;
      bus.m_wdata   <= '0;
      bus.m_wstrb   <= '0;
      bus.m_bready  <= 1'b0;
      bus.m_arvalid <= 1'b0;
      bus.m_araddr  <= '0;
      bus.m_rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ready && req_valid) begin
            req_ready <= 1'b0;
            if (req_we) begin
              bus.m_awvalid <= 1'b1;
              bus.m_wvalid  <= 1'b1;
              bus.m_awaddr  <= req_addr;
              bus.m_wdata   <= req_wdata;
              bus.m_wstrb   <= req_be;
              state         <= WADDR;
            end else begin
              bus.m_arvalid <= 1'b1;
              bus.m_araddr  <= req_addr;
              state         <= RADDR;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        WADDR: begin
          // AW and W complete independently; leave once both have been seen.
          if (aw_hs) begin
            bus.m_awvalid <= 1'b0;
            aw_done       <= 1'b1;
          end
          if (w_hs) begin
            bus.m_wvalid <= 1'b0;
            w_done       <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            bus.m_bready <= 1'b1;
            state        <= WRESP;
          end
        end
        WRESP: begin
          if (bus.m_bvalid) begin
            bus.m_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_err      <= resp_is_err(bus.m_bresp);
            state        <= RSP;
          end
        end
        RADDR: begin
          if (bus.m_arready) begin
            bus.m_arvalid <= 1'b0;
            bus.m_rready  <= 1'b1;
            state         <= RDATA;
          end
        end
        RDATA: begin
          if (bus.m_rvalid) begin
            bus.m_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= bus.m_rdata;
            rsp_err      <= resp_is_err(bus.m_rresp);
            state        <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IRIS_AXIL_INITIATOR_STATS_EN
  logic wr_fin;
  logic rd_fin;
  logic err_fin;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Events coincide with the RSP-entry edge of the FSM above.
  assign wr_fin  = (state == WRESP) && bus.m_bvalid;
  assign rd_fin  = (state == RDATA) && bus.m_rvalid;
  assign err_fin = (wr_fin && resp_is_err(bus.m_bresp)) || (rd_fin && resp_is_err(bus.m_rresp));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_wr_cnt  <= '0;
      stat_rd_cnt  <= '0;
      stat_err_cnt <= '0;
    end else begin
      if (wr_fin)  stat_wr_cnt  <= sat_inc(stat_wr_cnt);
      if (rd_fin)  stat_rd_cnt  <= sat_inc(stat_rd_cnt);
      if (err_fin) stat_err_cnt <= sat_inc(stat_err_cnt);
    end
  end
`else
  assign stat_wr_cnt  = '0;
  assign stat_rd_cnt  = '0;
  assign stat_err_cnt = '0;
`endif

endmodule

// File: tb/tb_iris_axil_initiator.sv
// Directed bench for iris_axil_initiator: configurable AXI-Lite responder plus response scoreboard.
module tb_iris_axil_initiator;
  localparam int DW = 24;
  localparam int AW = 16;
  localparam int SW = 16;
  localparam int BW = DW / 8;
`ifdef IRIS_AXIL_INITIATOR_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [SW-1:0] stat_wr_cnt, stat_rd_cnt, stat_err_cnt;

  always #5 clk = ~clk;

  iris_axil_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  iris_axil_initiator #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STAT_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus(bus),
    .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_err_cnt(stat_err_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0, n_fail = 0, issued = 0, rsp_seen = 0, b_cnt = 0;

  // Responder configuration: ready delays in cycles after valid rises, R latency, response codes.
  int            cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
  logic [1:0]    cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [DW-1:0] cfg_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Responder model
  int aw_c = 0, w_c = 0, ar_c = 0, r_wait = 0;
  bit aw_g = 0, w_g = 0, r_pend = 0;
  bit aw_h, w_h, b_h, ar_h, r_h;
  initial begin
    bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0; bus.m_bresp = 0;
    bus.m_arready = 0; bus.m_rvalid = 0; bus.m_rdata = 0; bus.m_rresp = 0;
    forever begin
      @(negedge clk);
      aw_h = bus.m_awvalid && bus.m_awready;
      w_h  = bus.m_wvalid && bus.m_wready;
      b_h  = bus.m_bvalid && bus.m_bready;
      ar_h = bus.m_arvalid && bus.m_arready;
      r_h  = bus.m_rvalid && bus.m_rready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0;
        bus.m_arready = 0; bus.m_rvalid = 0;
        aw_c = 0; w_c = 0; ar_c = 0; aw_g = 0; w_g = 0; r_pend = 0;
        continue;
      end
      if (aw_h) aw_g = 1;
      if (w_h) w_g = 1;
      if (b_h) begin bus.m_bvalid = 0; b_cnt++; end
      if (aw_g && w_g) begin
        bus.m_bvalid = 1; bus.m_bresp = cfg_bresp; aw_g = 0; w_g = 0;
      end
      if (r_h) bus.m_rvalid = 0;
      if (ar_h) begin r_pend = 1; r_wait = cfg_r_dly; end
      if (r_pend) begin
        if (r_wait == 0) begin
          bus.m_rvalid = 1; bus.m_rdata = cfg_rdata; bus.m_rresp = cfg_rresp; r_pend = 0;
        end else r_wait--;
      end
      if (bus.m_awvalid) begin bus.m_awready = (aw_c >= cfg_aw_dly); aw_c++; end
      else begin bus.m_awready = 0; aw_c = 0; end
      if (bus.m_wvalid) begin bus.m_wready = (w_c >= cfg_w_dly); w_c++; end
      else begin bus.m_wready = 0; w_c = 0; end
      if (bus.m_arvalid) begin bus.m_arready = (ar_c >= cfg_ar_dly); ar_c++; end
      else begin bus.m_arready = 0; ar_c = 0; end
    end
  end

  // Response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_rsp: rsp_valid=1 with no request pending, required 0");
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        end
        rsp_seen++;
      end
    end
  end

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [BW-1:0] be, input logic [DW-1:0] er, input logic ee);
    exp_t e;
    e.rdata = er;
    e.err   = ee;
    sb.push_back(e);
    issued++;
    req_we = we; req_addr = a; req_wdata = d; req_be = be; req_valid = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        req_valid = 0;
        return;
      end
    end
    n_vec++;
    n_fail++;
    $display("FAIL req_accept_timeout: req_ready=0 for 50 cycles, required 1");
    req_valid = 0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 100; i++) begin
      if (rsp_seen == issued) return;
      @(posedge clk);
      #1;
    end
    n_vec++;
    n_fail++;
    $display("FAIL rsp_timeout: %0d responses seen, required %0d", rsp_seen, issued);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b0, k;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 1;
    #1 rst_n = 0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_valids", {bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready, bus.m_rready}, 0);
    chk("rst_addr_data", 32'(bus.m_awaddr) | 32'(bus.m_araddr) | 32'(bus.m_wdata) | 32'(bus.m_wstrb), 0);
    chk("rst_stats", 32'(stat_wr_cnt) | 32'(stat_rd_cnt) | 32'(stat_err_cnt), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    step();

    // 1: zero-wait write, cycle-exact latency
    issue(1, 16'h0040, 24'hA5B6C7, 3'b111, 24'h0, 1'b0);
    chk("t1_awvalid_c1", 32'(bus.m_awvalid), 1);
    chk("t1_wvalid_c1", 32'(bus.m_wvalid), 1);
    chk("t1_awaddr", 32'(bus.m_awaddr), 32'h0040);
    chk("t1_wdata", 32'(bus.m_wdata), 32'hA5B6C7);
    chk("t1_wstrb", 32'(bus.m_wstrb), 3'b111);
    chk("t1_awprot", 32'(bus.m_awprot), 0);
    step();
    chk("t1_bready_c2", 32'(bus.m_bready), 1);
    step();
    chk("t1_rsp_valid_c3", 32'(rsp_valid), 1);
    wait_rsp();

    // 2: read with AR ready delayed 3 cycles
    cfg_ar_dly = 3; cfg_rdata = 24'h123456; cfg_rresp = 2'b00;
    issue(0, 16'h0080, 24'hFFFFFF, 3'b000, 24'h123456, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_arvalid_held", 32'(bus.m_arvalid), 1);
      chk("t2_araddr_stable", 32'(bus.m_araddr), 32'h0080);
      step();
    end
    chk("t2_arvalid_drop", 32'(bus.m_arvalid), 0);
    chk("t2_rready", 32'(bus.m_rready), 1);
    chk("t2_arprot", 32'(bus.m_arprot), 0);
    wait_rsp();
    cfg_ar_dly = 0;

    // 3: W accepted at cycle 1, AW at cycle 4
    cfg_aw_dly = 3; cfg_w_dly = 0; b0 = b_cnt;
    issue(1, 16'h0100, 24'h0F0F0F, 3'b101, 24'h0, 1'b0);
    chk("t3_valids_c1", {bus.m_awvalid, bus.m_wvalid}, 2'b11);
    chk("t3_wstrb", 32'(bus.m_wstrb), 3'b101);
    step();
    chk("t3_valids_c2", {bus.m_awvalid, bus.m_wvalid}, 2'b10);
    step();
    chk("t3_c3", {bus.m_awvalid, bus.m_bready}, 2'b10);
    step();
    chk("t3_c4", {bus.m_awvalid, bus.m_bready}, 2'b10);
    step();
    chk("t3_c5", {bus.m_awvalid, bus.m_bready}, 2'b01);
    wait_rsp();
    step();
    chk("t3_b_handshakes", b_cnt - b0, 1);
    cfg_aw_dly = 0;

    // 4: SLVERR write, DECERR read, EXOKAY write
    cfg_bresp = 2'b10;
    issue(1, 16'h0200, 24'h111111, 3'b011, 24'h0, 1'b1);
    wait_rsp();
    cfg_rresp = 2'b11; cfg_rdata = 24'h654321;
    issue(0, 16'h0204, 24'h0, 3'b000, 24'h654321, 1'b1);
    wait_rsp();
    cfg_bresp = 2'b01;
    issue(1, 16'h0208, 24'h222222, 3'b001, 24'h0, 1'b0);
    wait_rsp();
    cfg_bresp = 2'b00; cfg_rresp = 2'b00;
    chk("t4_stat_err", 32'(stat_err_cnt), STATS * 2);
    chk("t4_stat_wr", 32'(stat_wr_cnt), STATS * 4);
    chk("t4_stat_rd", 32'(stat_rd_cnt), STATS * 2);

    // 5: response backpressure with a pending request
    rsp_ready = 0; cfg_rdata = 24'hABCDEF;
    issue(0, 16'h0300, 24'h0, 3'b000, 24'hABCDEF, 1'b0);
    k = 0;
    while (!rsp_valid && k < 20) begin step(); k++; end
    chk("t5_rsp_valid_seen", 32'(rsp_valid), 1);
    req_we = 1; req_addr = 16'h0304; req_wdata = 24'h5A5A5A; req_be = 3'b110; req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      chk("t5_rsp_valid_hold", 32'(rsp_valid), 1);
      chk("t5_rsp_rdata_hold", 32'(rsp_rdata), 32'hABCDEF);
      chk("t5_req_ready_low", 32'(req_ready), 0);
      chk("t5_no_new_addr", {bus.m_awvalid, bus.m_arvalid}, 0);
      step();
    end
    mon_e.rdata = '0;
    mon_e.err   = 1'b0;
    sb.push_back(mon_e);
    issued++;
    rsp_ready = 1;
    @(negedge clk);
    chk("t5_no_accept_in_rsp", 32'(req_ready), 0);
    step();
    chk("t5_idle_cycle", {rsp_valid, req_ready, bus.m_awvalid}, 3'b010);
    step();
    chk("t5_next_aw", 32'(bus.m_awvalid), 1);
    chk("t5_next_awaddr", 32'(bus.m_awaddr), 32'h0304);
    chk("t5_next_wstrb", 32'(bus.m_wstrb), 3'b110);
    req_valid = 0;
    wait_rsp();

    // 6: reset while waiting in RDATA
    cfg_r_dly = 20;
    issue(0, 16'h0400, 24'h0, 3'b000, 24'h0, 1'b0);
    step();
    chk("t6_rready_before", 32'(bus.m_rready), 1);
    #2 rst_n = 0;
    #1;
    chk("t6_rready_async", 32'(bus.m_rready), 0);
    chk("t6_valids_async", {bus.m_awvalid, bus.m_wvalid, bus.m_arvalid, bus.m_bready, rsp_valid, req_ready}, 0);
    chk("t6_stat_rd_rst", 32'(stat_rd_cnt), 0);
    sb.delete();
    issued--;
    cfg_r_dly = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_rsp", 32'(rsp_valid), 0);
      step();
    end
    cfg_rdata = 24'h0BEEF0;
    issue(0, 16'h0404, 24'h0, 3'b000, 24'h0BEEF0, 1'b0);
    wait_rsp();
    chk("t6_stat_rd_after", 32'(stat_rd_cnt), STATS);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
